// File: rtl/max7219_sequencer.sv
// rtl/max7219_sequencer.sv - MAX7219 command sequencer: init list, framebuffer row refresh, intensity updates.
// Frames are 16-bit {4'h0, addr, data} words handed to the SPI shifter over valid/ready.
module max7219_sequencer #(
  parameter logic [2:0] SCAN_LIMIT   = 3'd7,
  parameter logic [7:0] DECODE_MODE  = 8'h00,
  parameter bit         AUTO_REFRESH = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        refresh_req,
  input  logic [3:0]  intensity,
  output logic [2:0]  fb_addr,
  input  logic [7:0]  fb_data,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic [15:0] frame_data,
  output logic        init_done,
  output logic        busy
);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_INTENS, S_FETCH, S_SEND} state_t;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [2:0]  row_q, row_d;
  logic        fv_q, fv_d;
  logic [15:0] data_q, data_d;
  logic        init_done_q, init_done_d;
  logic        pending_q, pending_d;
  logic [3:0]  last_int_q, last_int_d;

  function automatic logic [15:0] init_frame(input logic [2:0] idx, input logic [3:0] inten);
    case (idx)
      3'd0:    init_frame = 16'h0F00;
      3'd1:    init_frame = {8'h0B, 5'b0, SCAN_LIMIT};
      3'd2:    init_frame = {8'h09, DECODE_MODE};
      3'd3:    init_frame = {8'h0A, 4'h0, inten};
      default: init_frame = 16'h0C01;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_INIT;
      idx_q       <= 3'd0;
      row_q       <= 3'd0;
      fv_q        <= 1'b0;
      data_q      <= 16'h0000;
      init_done_q <= 1'b0;
      pending_q   <= 1'b0;
      last_int_q  <= 4'h0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      row_q       <= row_d;
      fv_q        <= fv_d;
      data_q      <= data_d;
      init_done_q <= init_done_d;
      pending_q   <= pending_d;
      last_int_q  <= last_int_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    row_d       = row_q;
    fv_d        = fv_q;
    data_d      = data_q;
    init_done_d = init_done_q;
    pending_d   = pending_q | refresh_req;
    last_int_d  = last_int_q;
    case (state_q)
      S_INIT: begin
        if (!fv_q) begin
          fv_d   = 1'b1;
          data_d = init_frame(idx_q, intensity);
        end else if (frame_ready) begin
          // The intensity actually sent is what must be remembered, not the live input
          if (idx_q == 3'd3) last_int_d = data_q[3:0];
          if (idx_q == 3'd4) begin
            fv_d        = 1'b0;
            init_done_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            idx_d  = idx_q + 3'd1;
            data_d = init_frame(idx_q + 3'd1, intensity);
          end
        end
      end
      S_IDLE: begin
        if (intensity != last_int_q) begin
          state_d = S_INTENS;
        end else if (pending_q || AUTO_REFRESH) begin
          // A pulse landing on the consuming cycle keeps the flag set
          pending_d = refresh_req;
          row_d     = 3'd0;
          state_d   = S_FETCH;
        end
      end
      S_INTENS: begin
        if (!fv_q) begin
          fv_d   = 1'b1;
          data_d = {8'h0A, 4'h0, intensity};
        end else if (frame_ready) begin
          fv_d       = 1'b0;
          last_int_d = data_q[3:0];
          state_d    = S_IDLE;
        end
      end
      S_FETCH: begin
        state_d = S_SEND;
      end
      S_SEND: begin
        if (!fv_q) begin
          fv_d   = 1'b1;
          data_d = {4'h0, {1'b0, row_q} + 4'd1, fb_data};
        end else if (frame_ready) begin
          fv_d = 1'b0;
          if (row_q == 3'd7) begin
            state_d = S_IDLE;
          end else begin
            row_d   = row_q + 3'd1;
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  assign fb_addr     = row_q;
  assign frame_valid = fv_q;
  assign frame_data  = data_q;
  assign init_done   = init_done_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_max7219_sequencer.sv
// tb/tb_max7219_sequencer.sv - directed bench for max7219_sequencer (manual and auto-refresh instances).
module tb_max7219_sequencer;

  logic        clk = 1'b0;
  logic        rst, refresh_req, frame_ready;
  logic [3:0]  intensity;
  logic [2:0]  fb_addr;
  logic [7:0]  fb_data;
  logic        frame_valid, init_done, busy;
  logic [15:0] frame_data;

  logic        rst_a, ready_a, refresh_a;
  logic [3:0]  intensity_a;
  logic [2:0]  fb_addr_a;
  logic [7:0]  fb_data_a;
  logic        valid_a, init_done_a, busy_a;
  logic [15:0] data_a;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int stall_viol = 0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data = 16'h0;

  logic [7:0]  fb_mem [8];
  logic [15:0] pass_exp [8];
  logic [15:0] init_exp [5];
  logic [15:0] fq[$];
  int          fstamp[$];
  logic [15:0] aq[$];
  int          runs[$];
  int          run_len = 0;

  max7219_sequencer dut (
    .clk(clk), .rst(rst), .refresh_req(refresh_req), .intensity(intensity),
    .fb_addr(fb_addr), .fb_data(fb_data), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .frame_data(frame_data), .init_done(init_done), .busy(busy)
  );

  max7219_sequencer #(.AUTO_REFRESH(1'b1)) dut_auto (
    .clk(clk), .rst(rst_a), .refresh_req(refresh_a), .intensity(intensity_a),
    .fb_addr(fb_addr_a), .fb_data(fb_data_a), .frame_valid(valid_a),
    .frame_ready(ready_a), .frame_data(data_a), .init_done(init_done_a), .busy(busy_a)
  );

  always #5 clk = ~clk;

  // Registered framebuffer read: data appears one cycle after the address
  always @(posedge clk) begin
    cyc       <= cyc + 1;
    fb_data   <= fb_mem[fb_addr];
    fb_data_a <= fb_mem[fb_addr_a];
  end

  // Inputs only change at posedge+1, so the negedge view predicts the next edge's transfer
  always @(negedge clk) begin
    if (frame_valid && frame_ready) begin
      fq.push_back(frame_data);
      fstamp.push_back(cyc);
    end
    if (prev_stall && frame_valid && frame_data != prev_data) stall_viol++;
    prev_stall = frame_valid && !frame_ready;
    prev_data  = frame_data;
    if (valid_a && ready_a) aq.push_back(data_a);
    if (!rst_a && init_done_a) begin
      if (!busy_a) run_len++;
      else if (run_len > 0) begin
        runs.push_back(run_len);
        run_len = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_frames(input int n);
    int budget = 0;
    while (fq.size() < n && budget < 3000) begin
      step();
      budget++;
    end
    check("frame_count", fq.size(), n);
  endtask

  task automatic pulse_refresh();
    refresh_req = 1'b1;
    step();
    refresh_req = 1'b0;
  endtask

  task automatic check_pass(input string tag, input int base);
    for (int i = 0; i < 8; i++)
      if (base + i < fq.size()) check(tag, fq[base + i], pass_exp[i]);
      else check(tag, 32'hDEAD, pass_exp[i]);
  endtask

  initial begin
    fb_mem   = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h18, 8'h24, 8'h42, 8'h81};
    pass_exp = '{16'h0181, 16'h0242, 16'h0324, 16'h0418, 16'h0518, 16'h0624, 16'h0742, 16'h0881};
    init_exp = '{16'h0F00, 16'h0B07, 16'h0900, 16'h0A05, 16'h0C01};
    rst = 1'b1; refresh_req = 1'b0; frame_ready = 1'b1; intensity = 4'h5;
    rst_a = 1'b1; ready_a = 1'b1; refresh_a = 1'b0; intensity_a = 4'h5;
    #2;
    check("rst_valid", frame_valid, 1'b0);
    check("rst_data", frame_data, 16'h0000);
    check("rst_addr", fb_addr, 3'd0);
    check("rst_init_done", init_done, 1'b0);
    check("rst_busy", busy, 1'b1);

    // Init list back-to-back
    step();
    rst = 1'b0;
    wait_frames(5);
    for (int i = 0; i < 5; i++) check("init_frame", fq[i], init_exp[i]);
    for (int i = 1; i < 5; i++) check("init_gapless", fstamp[i] - fstamp[i-1], 1);
    check("init_done", init_done, 1'b1);
    check("idle_busy", busy, 1'b0);

    // One refresh pass
    repeat (3) step();
    fq.delete();
    pulse_refresh();
    wait_frames(8);
    check_pass("pass1", 0);
    repeat (3) step();
    check("pass1_idle", busy, 1'b0);

    // Random backpressure
    fq.delete();
    pulse_refresh();
    for (int b = 0; b < 2000 && fq.size() < 8; b++) begin
      frame_ready = 1'($urandom_range(0, 1));
      step();
    end
    frame_ready = 1'b1;
    check("bp_count", fq.size(), 8);
    check_pass("bp_pass", 0);
    check("bp_stable", stall_viol, 0);
    repeat (10) step();

    // Intensity change and two refresh pulses mid-pass
    fq.delete();
    pulse_refresh();
    wait_frames(3);
    intensity = 4'h9;
    pulse_refresh();
    step();
    pulse_refresh();
    wait_frames(17);
    check_pass("mid_pass_a", 0);
    check("mid_intens", fq[8], 16'h0A09);
    check_pass("mid_pass_b", 9);
    repeat (60) step();
    check("mid_no_extra", fq.size(), 17);
    check("mid_idle", busy, 1'b0);

    // Reset while 0x0B07 is stalled
    frame_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int b = 0; b < 50 && !frame_valid; b++) step();
    check("rr_first", frame_data, 16'h0F00);
    frame_ready = 1'b1;
    step();
    frame_ready = 1'b0;
    check("rr_pending_valid", frame_valid, 1'b1);
    check("rr_pending_data", frame_data, 16'h0B07);
    rst = 1'b1;
    #1;
    check("rr_async_valid", frame_valid, 1'b0);
    check("rr_async_data", frame_data, 16'h0000);
    check("rr_async_busy", busy, 1'b1);
    check("rr_async_done", init_done, 1'b0);
    step();
    rst = 1'b0;
    fq.delete();
    frame_ready = 1'b1;
    wait_frames(5);
    check("rr_f0", fq[0], 16'h0F00);
    check("rr_f1", fq[1], 16'h0B07);
    check("rr_f2", fq[2], 16'h0900);
    check("rr_f3", fq[3], 16'h0A09);
    check("rr_f4", fq[4], 16'h0C01);

    // Auto-refresh instance
    step();
    rst_a = 1'b0;
    for (int b = 0; b < 3000 && aq.size() < 22; b++) step();
    check("auto_count", aq.size(), 22);
    if (aq.size() >= 21) begin
      for (int i = 0; i < 8; i++) check("auto_pass1", aq[5 + i], pass_exp[i]);
      for (int i = 0; i < 8; i++) check("auto_pass2", aq[13 + i], pass_exp[i]);
    end
    check("auto_wrap", {aq[12], aq[13]}, {16'h0881, 16'h0181});
    check("auto_runs", runs.size() >= 2, 1'b1);
    if (runs.size() >= 2) begin
      check("auto_idle_init", runs[0], 1);
      check("auto_idle_gap", runs[1], 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/max7219_sequencer.md
Name: max7219_sequencer

Overview:
- Command sequencer for the MAX7219 8x8 matrix driver. Replaces the free-running hardcoded command ROM loop.
- After reset it issues the MAX7219 init command list once. It then writes the 8 digit (row) registers from an external 8x8 framebuffer whenever a refresh is requested, and re-issues the intensity command whenever the intensity input changes.
- Feeds 16-bit frames over a valid/ready handshake to the SPI frame shifter, which owns CS and bit timing.

Parameters:
- SCAN_LIMIT, 3'd7, value sent to the scan-limit register (0x0B).
- DECODE_MODE, 8'h00, value sent to the decode-mode register (0x09).
- AUTO_REFRESH, 1'b0, 1 = start a new refresh pass immediately after each pass ends, without waiting for refresh_req.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- rst, input, 1, asynchronous active-high reset.
- refresh_req, input, 1, single-cycle pulse; requests one full 8-row refresh pass.
- intensity, input, 4, display brightness level 0..15.
- fb_addr, output, 3, framebuffer row address (row 0..7).
- fb_data, input, 8, framebuffer row data; valid exactly 1 cycle after fb_addr is presented (registered RAM read).
- frame_valid, output, 1, frame_data holds a frame for the SPI shifter.
- frame_ready, input, 1, SPI shifter accepts the frame.
- frame_data, output, 16, MAX7219 command as {4'h0, addr[3:0], data[7:0]}, MSB first.
- init_done, output, 1, high once the init list has been fully accepted.
- busy, output, 1, high in every state except IDLE.

Behaviour:
- Reset values: frame_valid=0, frame_data=16'h0000, fb_addr=0, init_done=0, busy=1 (state INIT), refresh_pending=0, last_intensity=0.
- A transfer occurs on a rising edge where frame_valid && frame_ready.
- While frame_valid=1 and frame_ready=0, frame_data must be held stable.
- frame_valid deasserts only on the edge of an accepting transfer, or when the next frame is loaded in the same cycle.
- Latency: a frame is presented on the first edge after entry to a send state. There are no bubble cycles between consecutive init frames while frame_ready is held high.

State machine:
- INIT: issues 5 frames in this order, indexed by a 3-bit counter:
  - 0x0F00 (display test off)
  - {8'h0B, 5'b0, SCAN_LIMIT}
  - {8'h09, DECODE_MODE}
  - {8'h0A, 4'h0, intensity} (latch intensity into last_intensity when this frame is accepted)
  - 0x0C01 (normal operation)
  - After the 5th transfer: init_done<=1, go to IDLE.
- IDLE: busy=0.
  - If intensity != last_intensity, go to INTENS. This has priority over refresh.
  - Else if refresh_pending or AUTO_REFRESH, clear refresh_pending, set row=0, go to FETCH.
- INTENS: present {8'h0A, 4'h0, intensity} sampled on state entry. On transfer, latch that value into last_intensity and return to IDLE.
- FETCH: drive fb_addr=row for one cycle, then go to SEND.
- SEND: present {4'h0, row+1 (4 bits), fb_data captured on the SEND entry edge}.
  - On transfer: if row==7 go to IDLE; else row<=row+1 and go to FETCH.
  - A pass is therefore 8 frames at digit addresses 0x01..0x08.

Boundary conditions:
- refresh_req arriving in any state (INIT, mid-pass, INTENS) sets refresh_pending. Multiple pulses before service merge into one pass. A pulse during a pass causes exactly one further pass.
- refresh_req pulse in the same cycle IDLE consumes refresh_pending: the pending flag stays set.
- Intensity change mid-pass: the change is not applied until the pass completes. Only the latest value is sent.
- An intensity change during INIT after frame 3 has been accepted is caught by the IDLE compare.
- Reset mid-frame (frame_valid=1, not yet accepted): all outputs return to reset values immediately. The init list restarts from frame 0 after reset release.
- The row counter is 3 bits and never wraps past 7 within a pass.

Test Plan:
- Reset release, frame_ready=1 constantly, intensity=4'h5 -> exactly 5 transfers 0x0F00, 0x0B07, 0x0900, 0x0A05, 0x0C01 on 5 consecutive edges; init_done=1; busy=0.
- After init, fb rows = 8'h81,42,24,18,18,24,42,81, one refresh_req pulse -> 8 transfers 0x0181, 0x0242, 0x0324, 0x0418, 0x0518, 0x0624, 0x0742, 0x0881, then IDLE.
- frame_ready toggled pseudo-randomly during a pass -> frame_data stable whenever frame_valid=1 && frame_ready=0; same 8-frame sequence; no frame lost or duplicated.
- intensity 5->9 mid-pass, plus 2 refresh_req pulses mid-pass -> pass completes; then 0x0A09; then exactly one more 8-frame pass.
- rst asserted while frame 0x0B07 is pending with frame_ready=0 -> frame_valid=0 asynchronously; after release the sequence restarts with 0x0F00.
- AUTO_REFRESH=1, frame_ready=1 -> back-to-back passes with digit address wrapping 0x08 -> 0x01; busy returns low for exactly one cycle between passes.
